// File: rtl/seq_detect_pkg.sv
// Shared types and default constants for the serial sequence detector.
package seq_detect_pkg;

    typedef logic [0:0] state_t;

    localparam state_t FILL  = 1'b0;
    localparam state_t ARMED = 1'b1;

    localparam int         DEF_PAT_LEN = 3;
    localparam logic [2:0] DEF_PATTERN = 3'b111;
    localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detect_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and soft clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count state: reset/clear to zero, increment until all ones, then hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else if (clr) begin
            count_q <= {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect.sv
// Serial bit-pattern detector with registered match pulse and sticky error flag.
// Define SEQ_DETECT_COUNT_EN to build in the saturating match counter.
module seq_detect
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr,
    output logic             match,
    output logic             error,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] win_q;
    logic [PAT_LEN-1:0] win_d;
    logic [PAT_LEN-1:0] win_shift_s;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    state_t             state_q;
    state_t             state_d;
    logic               hit_s;
    logic               match_q;
    logic               error_q;

    // Next window, fill count and FSM state; hit_s flags a completed pattern this cycle.
    always_comb begin
        win_d       = win_q;
        fill_d      = fill_q;
        state_d     = state_q;
        hit_s       = 1'b0;
        win_shift_s = {win_q[PAT_LEN-2:0], din};
        if (clr) begin
            win_d   = {PAT_LEN{1'b0}};
            fill_d  = {FILL_W{1'b0}};
            state_d = FILL;
        end else if (din_valid) begin
            case (state_q)
                FILL: begin
                    if (fill_q == LAST_FILL) begin
                        state_d = ARMED;
                        fill_d  = {FILL_W{1'b0}};
                        hit_s   = (win_shift_s == PATTERN);
                    end else begin
                        fill_d  = fill_q + FILL_W'(1);
                    end
                end
                ARMED: begin
                    hit_s = (win_shift_s == PATTERN);
                end
                default: begin
                    state_d = FILL;
                    fill_d  = {FILL_W{1'b0}};
                end
            endcase
            // Non-overlapping mode restarts from an empty window after every match.
            if (hit_s && (OVERLAP == 0)) begin
                win_d   = {PAT_LEN{1'b0}};
                fill_d  = {FILL_W{1'b0}};
                state_d = FILL;
            end else begin
                win_d   = win_shift_s;
            end
        end else begin
            win_d = win_q;
        end
    end

    // State and output registers; reset dominates clear, clear dominates data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q   <= {PAT_LEN{1'b0}};
            fill_q  <= {FILL_W{1'b0}};
            state_q <= FILL;
            match_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            match_q <= hit_s;
            error_q <= clr ? 1'b0 : (error_q | hit_s);
        end
    end

    assign match = match_q;
    assign error = error_q;

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] count_s;

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (hit_s),
        .count (count_s)
    );

    assign match_count = count_s;
`else
    assign match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/seq_detect.md
SEQ_DETECT -- requirements
Module: seq_detect

Interface
REQ-001 Parameter PAT_LEN, default 3, SHALL set the pattern length in bits (legal range 2..32).
REQ-002 Parameter PATTERN, default 3'b111 (width PAT_LEN), SHALL set the detected bit sequence; MSB is the oldest bit.
REQ-003 Parameter OVERLAP, default 1, SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-004 Parameter CNT_W, default 8, SHALL set the match-counter width.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port din, input, 1: serial data bit.
REQ-008 Port din_valid, input, 1: din is sampled only when high.
REQ-009 Port clr, input, 1: synchronous soft clear of window, state and counter.
REQ-010 Port match, output, 1: one-cycle pulse per detected pattern.
REQ-011 Port error, output, 1: sticky flag, set on first match, held until reset or clr.
REQ-012 Port match_count, output, CNT_W: number of matches since reset or clr.

Function
REQ-013 A PAT_LEN-bit shift window SHALL shift in din at its LSB on each cycle with din_valid=1; the window SHALL hold when din_valid=0.
REQ-014 The FSM SHALL have states FILL (fewer than PAT_LEN valid bits since the last restart) and ARMED (window fully populated).
REQ-015 FILL SHALL count accepted bits and enter ARMED on the cycle the PAT_LEN-th bit is accepted.
REQ-016 A match SHALL be the case where the window, including the bit accepted this cycle, equals PATTERN, and the FSM is ARMED or is completing FILL this cycle.
REQ-017 match SHALL be registered and assert exactly one cycle after the completing bit's clock edge (latency 1), and SHALL be low otherwise.
REQ-018 With OVERLAP=1, the FSM SHALL stay ARMED after a match; for example, PATTERN=111 on input 1111 SHALL produce 2 matches.
REQ-019 With OVERLAP=0, a match SHALL clear the window and return the FSM to FILL with fill count 0; PATTERN=111 on input 1111 SHALL produce 1 match.
REQ-020 Bits accepted before the window is full SHALL never produce a match.
REQ-021 error SHALL set on the same cycle match first asserts, and SHALL remain 1 regardless of later input.
REQ-022 match_count SHALL increment with each match pulse and SHALL saturate at 2^CNT_W-1, with no wrap-around.
REQ-023 clr SHALL have priority over din_valid in the same cycle: the bit SHALL be discarded, the FSM SHALL go to FILL, and match, error and match_count SHALL be 0 on the next cycle.
REQ-024 If a completing bit and clr coincide, no match SHALL be reported.

Reset
REQ-025 While rst_n=0 at a clock edge: window=0, fill count=0, FSM=FILL, match=0, error=0, match_count=0.
REQ-026 Reset asserted mid-pattern SHALL discard the partial sequence; detection after reset SHALL require a full PAT_LEN new bits.
REQ-027 rst_n SHALL have priority over clr and din_valid.

Configuration
REQ-028 Macro SEQ_DETECT_COUNT_EN SHALL compile the match_count counter in.
- Defined: match_count SHALL behave per REQ-022.
- Undefined: the counter logic SHALL be absent and match_count SHALL be tied to 0. Ports are unchanged.

Structure
REQ-029 Package seq_detect_pkg SHALL hold the FSM state typedef (FILL, ARMED) and the default constants for PAT_LEN, PATTERN and CNT_W.
REQ-030 The saturating counter SHALL be a separate sub-module sat_counter, with parameter W and ports clk, rst_n, clr, inc, count.

Verification
REQ-031 Defaults, din_valid=1, input 1,1,1 -> match pulses once, one cycle after the third bit; error=1; match_count=1.
REQ-032 Defaults, input 1,1,1,1,1 -> 3 match pulses on consecutive cycles; match_count=3.
REQ-033 OVERLAP=0, input 1,1,1,1,1,1 -> 2 matches, after bits 3 and 6; bits 4-5 produce no match.
REQ-034 Defaults, input 1,1 with din_valid low for 4 cycles, then 1 -> exactly one match, after the final bit; no match during the gap.
REQ-035 CNT_W=2, 6 overlapping matches -> match_count holds 3; then clr -> match_count=0 and error=0 on the next cycle.
REQ-036 Input 1,1, rst_n low for 1 cycle, then 1 -> no match; a further 1,1 -> a match after the third post-reset bit.
